// File: rtl/spi_seq_pkg.sv
// Shared types and register map for the SPI-over-APB transfer sequencer.
// Offsets are word indices; the byte address is {base, offset, 2'b00}.
package spi_seq_pkg;

  localparam int unsigned APB_AW = 16;

  localparam logic [3:0] OFF_CONFIG = 4'd0;
  localparam logic [3:0] OFF_STATE  = 4'd0;
  localparam logic [3:0] OFF_TX     = 4'd1;
  localparam logic [3:0] OFF_RX     = 4'd1;
  localparam logic [3:0] OFF_CMD    = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_GAP,
    S_FINISH
  } seq_state_e;

  typedef enum logic [2:0] {
    STEP_WR_CFG,
    STEP_WR_TX,
    STEP_WR_CMD,
    STEP_RD_STATE,
    STEP_RD_RX
  } seq_step_e;

  function automatic logic [3:0] step_offset(input seq_step_e s);
    case (s)
      STEP_WR_CFG:   return OFF_CONFIG;
      STEP_WR_TX:    return OFF_TX;
      STEP_WR_CMD:   return OFF_CMD;
      STEP_RD_STATE: return OFF_STATE;
      default:       return OFF_RX;
    endcase
  endfunction

  function automatic logic step_is_write(input seq_step_e s);
    return (s == STEP_WR_CFG) || (s == STEP_WR_TX) || (s == STEP_WR_CMD);
  endfunction

endpackage

// File: rtl/spi_apb_sequencer_if.sv
// APB master bus between the sequencer and the SPI controller's register block.
interface spi_apb_sequencer_if;
  import spi_seq_pkg::*;

  logic              o_PSEL;
  logic              o_PENABLE;
  logic              o_PWRITE;
  logic [APB_AW-1:0] o_PADDR;
  logic [7:0]        o_PWDATA;
  logic              i_PREADY;
  logic [7:0]        i_PRDATA;

  modport master (
    output o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA,
    input  i_PREADY, i_PRDATA
  );

  modport slave (
    input  o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA,
    output i_PREADY, i_PRDATA
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: ptr names the requester that wins a tie.
module rr_arbiter2 (
  input  logic       i_PCLK,
  input  logic       i_PRESET,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       idx
);

  logic ptr;

  always_comb begin
    idx = 1'b0;
    if (req == 2'b11) idx = ptr;
    else              idx = req[1];
    gnt = (|req) ? (idx ? 2'b10 : 2'b01) : 2'b00;
  end

  // The winner of an accepted grant loses the next tie.
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET)          ptr <= 1'b0;
    else if (take && |req) ptr <= ~idx;
  end

endmodule

// File: rtl/spi_apb_sequencer.sv
// Runs one SPI transfer per grant over APB: CONFIG, TX, CMD writes, STATE polling, RX read.
module spi_apb_sequencer
  import spi_seq_pkg::*;
#(
  parameter logic [9:0]  P_BASE_ADDR = 10'h000,
  parameter logic [7:0]  P_CMD_START = 8'h01,
  parameter int unsigned P_DONE_BIT  = 0,
  parameter int unsigned P_POLL_GAP  = 4,
  parameter int unsigned P_MAX_POLLS = 255
) (
  input  logic                       i_PCLK,
  input  logic                       i_PRESET,
  input  logic [1:0]                 i_REQ,
  input  logic [7:0]                 i_CFG0,
  input  logic [7:0]                 i_CFG1,
  input  logic [7:0]                 i_TX0,
  input  logic [7:0]                 i_TX1,
  output logic [1:0]                 o_GNT,
  output logic                       o_DONE,
  output logic                       o_DONE_ID,
  output logic                       o_ERR,
  output logic [7:0]                 o_RX_DATA,
  spi_apb_sequencer_if.master        apb
);

  localparam logic [7:0] MAX_POLLS = 8'(P_MAX_POLLS);
  localparam logic [3:0] POLL_GAP  = 4'(P_POLL_GAP);
  localparam logic [2:0] DONE_IDX  = 3'(P_DONE_BIT);

  seq_state_e state_q;
  seq_step_e  step_q;
  logic [7:0] poll_cnt;
  logic [3:0] gap_cnt;
  logic [7:0] cfg_q;
  logic [7:0] tx_q;
  logic       idx_q;

  logic [1:0] arb_gnt;
  logic       arb_idx;

  rr_arbiter2 u_arb (
    .i_PCLK   (i_PCLK),
    .i_PRESET (i_PRESET),
    .req      (i_REQ),
    .take     (state_q == S_IDLE),
    .gnt      (arb_gnt),
    .idx      (arb_idx)
  );

  // Transition decisions; the sequential block below only applies them.
  logic      go_setup, go_gap, go_finish, fin_err, poll_inc;
  seq_step_e ld_step;
  logic [APB_AW-1:0] ld_addr;
  logic      ld_write;
  logic [7:0] ld_wdata;

  always_comb begin
    go_setup  = 1'b0;
    go_gap    = 1'b0;
    go_finish = 1'b0;
    fin_err   = 1'b0;
    poll_inc  = 1'b0;
    case (state_q)
      S_IDLE:   go_setup = |i_REQ;
      S_ACCESS: begin
        if (apb.i_PREADY) begin
          case (step_q)
            STEP_RD_STATE: begin
              if (apb.i_PRDATA[DONE_IDX]) begin
                go_setup = 1'b1;
              end else begin
                poll_inc = 1'b1;
                if (poll_cnt == MAX_POLLS - 8'd1) begin
                  go_finish = 1'b1;
                  fin_err   = 1'b1;
                end else begin
                  go_gap = 1'b1;
                end
              end
            end
            STEP_RD_RX: go_finish = 1'b1;
            default:    go_setup  = 1'b1;
          endcase
        end
      end
      S_GAP:    go_setup = (gap_cnt <= 4'd1);
      default:  ;
    endcase
  end

  always_comb begin
    ld_step = STEP_WR_CFG;
    case (state_q)
      S_IDLE: ld_step = STEP_WR_CFG;
      S_GAP:  ld_step = STEP_RD_STATE;
      default: begin
        case (step_q)
          STEP_WR_CFG:   ld_step = STEP_WR_TX;
          STEP_WR_TX:    ld_step = STEP_WR_CMD;
          STEP_WR_CMD:   ld_step = STEP_RD_STATE;
          default:       ld_step = STEP_RD_RX;
        endcase
      end
    endcase
    ld_addr  = {P_BASE_ADDR, step_offset(ld_step), 2'b00};
    ld_write = step_is_write(ld_step);
    case (ld_step)
      STEP_WR_CFG: ld_wdata = arb_idx ? i_CFG1 : i_CFG0;
      STEP_WR_TX:  ld_wdata = tx_q;
      STEP_WR_CMD: ld_wdata = P_CMD_START;
      default:     ld_wdata = '0;
    endcase
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state_q       <= S_IDLE;
      step_q        <= STEP_WR_CFG;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      cfg_q         <= '0;
      tx_q          <= '0;
      idx_q         <= 1'b0;
      o_GNT         <= '0;
      o_DONE        <= 1'b0;
      o_DONE_ID     <= 1'b0;
      o_ERR         <= 1'b0;
      o_RX_DATA     <= '0;
      apb.o_PSEL    <= 1'b0;
      apb.o_PENABLE <= 1'b0;
      apb.o_PWRITE  <= 1'b0;
      apb.o_PADDR   <= '0;
      apb.o_PWDATA  <= '0;
    end else begin
      o_DONE <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_setup) begin
            o_GNT    <= arb_gnt;
            idx_q    <= arb_idx;
            cfg_q    <= arb_idx ? i_CFG1 : i_CFG0;
            tx_q     <= arb_idx ? i_TX1 : i_TX0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
          end
        end
        S_SETUP: begin
          apb.o_PENABLE <= 1'b1;
          state_q       <= S_ACCESS;
        end
        S_GAP:    if (!go_setup) gap_cnt <= gap_cnt - 4'd1;
        S_FINISH: state_q <= S_IDLE;
        default:  ;
      endcase

      if (poll_inc && poll_cnt != 8'hFF) poll_cnt <= poll_cnt + 8'd1;

      if (go_setup) begin
        step_q        <= ld_step;
        apb.o_PSEL    <= 1'b1;
        apb.o_PENABLE <= 1'b0;
        apb.o_PWRITE  <= ld_write;
        apb.o_PADDR   <= ld_addr;
        apb.o_PWDATA  <= ld_wdata;
        state_q       <= S_SETUP;
      end

      if (go_gap || go_finish) begin
        apb.o_PSEL    <= 1'b0;
        apb.o_PENABLE <= 1'b0;
        apb.o_PWRITE  <= 1'b0;
        apb.o_PADDR   <= '0;
        apb.o_PWDATA  <= '0;
      end

      if (go_gap) begin
        gap_cnt <= POLL_GAP;
        state_q <= S_GAP;
      end

      if (go_finish) begin
        o_GNT     <= '0;
        o_DONE    <= 1'b1;
        o_DONE_ID <= idx_q;
        o_ERR     <= fin_err;
        o_RX_DATA <= fin_err ? 8'h00 : apb.i_PRDATA;
        state_q   <= S_FINISH;
      end
    end
  end

endmodule
